// File: rtl/ds_decimator.sv
// Power-of-two decimator between the ADC capture path and the downstream consumer.
// Picks or boxcar-averages each group of 2^ratio_log2 samples into a 2-entry output FIFO.
module ds_decimator #(
    parameter int DATA_WIDTH = 14,
    parameter int MAX_LOG2   = 4,
    parameter int LOG2_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  in_valid,
    input  logic [LOG2_W-1:0]     ratio_log2,
    input  logic                  mode,
    input  logic                  sync,
    output logic [DATA_WIDTH-1:0] dsoutdata,
    output logic                  out_en,
    input  logic                  outbusy,
    output logic                  ovf
);

    localparam int ACC_W = DATA_WIDTH + MAX_LOG2;
    localparam int CNT_W = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;

    logic [CNT_W-1:0]        count;
    logic [LOG2_W-1:0]       cfg_log2;
    logic                    cfg_mode;
    logic signed [ACC_W-1:0] acc;
    logic [DATA_WIDTH-1:0]   first_sample;

    logic [DATA_WIDTH-1:0]   fifo_mem [2];
    logic                    rd_ptr;
    logic                    wr_ptr;
    logic [1:0]              fifo_cnt;
    logic                    ovf_r;

    logic [LOG2_W-1:0]       in_log2;
    logic [LOG2_W-1:0]       grp_log2;
    logic                    grp_mode;
    logic                    group_start;
    logic                    group_last;
    logic [CNT_W-1:0]        last_idx;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] sum;
    logic [DATA_WIDTH-1:0]   avg_result;
    logic [DATA_WIDTH-1:0]   result;
    logic                    push;
    logic                    push_ok;
    logic                    pop;
    logic                    fifo_empty;
    logic                    fifo_full;

    always_comb begin
        in_log2 = ratio_log2;
        if (ratio_log2 > LOG2_W'(MAX_LOG2)) begin
            in_log2 = LOG2_W'(MAX_LOG2);
        end
    end

    // The first sample of a group runs on the live config, later ones on the latched copy.
    always_comb begin
        group_start = (count == '0);
        grp_log2    = group_start ? in_log2 : cfg_log2;
        grp_mode    = group_start ? mode : cfg_mode;
        last_idx    = CNT_W'((32'd1 << grp_log2) - 32'd1);
        group_last  = (count == last_idx);
    end

    always_comb begin
        sample_ext = ACC_W'($signed(dataIn));
        acc_base   = group_start ? '0 : acc;
        sum        = acc_base + sample_ext;
        avg_result = DATA_WIDTH'(sum >>> grp_log2);
        result     = grp_mode ? avg_result : (group_start ? dataIn : first_sample);
    end

    always_comb begin
        fifo_empty = (fifo_cnt == 2'd0);
        fifo_full  = (fifo_cnt == 2'd2);
        out_en     = !fifo_empty && !outbusy && !sync;
        pop        = out_en;
        push       = in_valid && !sync && group_last;
        push_ok    = push && (!fifo_full || pop);
        dsoutdata  = fifo_empty ? '0 : fifo_mem[rd_ptr];
        ovf        = ovf_r;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= '0;
            acc          <= '0;
            first_sample <= '0;
            cfg_log2     <= '0;
            cfg_mode     <= 1'b0;
        end else if (sync) begin
            count <= '0;
            acc   <= '0;
        end else if (in_valid) begin
            if (group_start) begin
                cfg_log2     <= in_log2;
                cfg_mode     <= mode;
                first_sample <= dataIn;
            end
            if (group_last) begin
                count <= '0;
                acc   <= '0;
            end else begin
                count <= count + CNT_W'(1);
                acc   <= sum;
            end
        end
    end

    // When full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
            ovf_r       <= 1'b0;
        end else if (sync) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
            ovf_r    <= 1'b0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= result;
                wr_ptr           <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            if (push && !push_ok) begin
                ovf_r <= 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_ds_decimator.sv
// Scoreboard bench for ds_decimator: expected results are queued as groups complete
// and compared against the FIFO head and out_en every cycle.
module tb_ds_decimator;

    typedef struct {
        logic v;
        int   d;
        logic b;
        logic s;
        int   r;
        logic m;
        logic done;
        int   res;
    } vec_t;

    logic              clk;
    logic              rst;
    logic signed [13:0] dataIn;
    logic              in_valid;
    logic [2:0]        ratio_log2;
    logic              mode;
    logic              sync;
    logic signed [13:0] dsoutdata;
    logic              out_en;
    logic              outbusy;
    logic              ovf;

    int                tests_run;
    int                tests_failed;
    logic signed [13:0] sb[$];
    logic              exp_ovf;

    ds_decimator dut (
        .clk        (clk),
        .rst        (rst),
        .dataIn     (dataIn),
        .in_valid   (in_valid),
        .ratio_log2 (ratio_log2),
        .mode       (mode),
        .sync       (sync),
        .dsoutdata  (dsoutdata),
        .out_en     (out_en),
        .outbusy    (outbusy),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input int d, input logic b, input logic s,
                                input int r, input logic m, input logic done, input int res);
        vec_t t;
        t.v = v; t.d = d; t.b = b; t.s = s; t.r = r; t.m = m; t.done = done; t.res = res;
        return t;
    endfunction

    // Inputs change just after the rising edge; outputs are observed on the falling edge.
    task automatic step(input vec_t t);
        @(posedge clk);
        #1;
        in_valid   = t.v;
        dataIn     = 14'(t.d);
        outbusy    = t.b;
        sync       = t.s;
        ratio_log2 = 3'(t.r);
        mode       = t.m;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        in_valid = 0; dataIn = '0; outbusy = 0; sync = 0; ratio_log2 = '0; mode = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_ovf = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 0; dataIn = '0; outbusy = 0; sync = 0; ratio_log2 = '0; mode = 0;
        #2 rst = 1'b1;
        #2;
        tests_run += 3;
        if (out_en !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset out_en: got %b want 0", out_en);
        end
        if (dsoutdata !== 14'sd0) begin
            tests_failed++;
            $display("[TB] FAIL reset data: got %0d want 0", dsoutdata);
        end
        if (ovf !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset ovf: got %b want 0", ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_ovf = 1'b0;
    endtask

    task automatic test_pick();
        vec_t tbl[$];
        logic exp_en;
        logic signed [13:0] exp_d;
        do_reset();
        for (int k = 0; k < 14; k++)
            tbl.push_back(mk(k < 12, k, 0, 0, 2, 0, (k < 12) && (k % 4 == 3), k - 3));
        foreach (tbl[k]) begin
            step(tbl[k]);
            exp_en = (sb.size() != 0) && !tbl[k].b && !tbl[k].s;
            exp_d  = (sb.size() != 0) ? sb[0] : '0;
            tests_run += 3;
            if (out_en !== exp_en) begin
                tests_failed++;
                $display("[TB] FAIL pick out_en step %0d: got %b want %b", k, out_en, exp_en);
            end
            if (dsoutdata !== exp_d) begin
                tests_failed++;
                $display("[TB] FAIL pick data step %0d: got %0d want %0d", k, dsoutdata, exp_d);
            end
            if (ovf !== exp_ovf) begin
                tests_failed++;
                $display("[TB] FAIL pick ovf step %0d: got %b want %b", k, ovf, exp_ovf);
            end
            if (exp_en) void'(sb.pop_front());
            if (tbl[k].s) begin sb.delete(); exp_ovf = 1'b0; end
            else if (tbl[k].v && tbl[k].done) begin
                if (sb.size() < 2) sb.push_back(14'(tbl[k].res)); else exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic test_average();
        vec_t tbl[$];
        logic exp_en;
        logic signed [13:0] exp_d;
        int samples[8] = '{-8191, -8192, -8192, -8192, 1, 2, 2, 2};
        do_reset();
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(1, samples[k], 0, 0, 2, 1, (k == 3) || (k == 7), (k == 3) ? -8192 : 1));
        tbl.push_back(mk(0, 0, 0, 0, 2, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2, 1, 0, 0));
        foreach (tbl[k]) begin
            step(tbl[k]);
            exp_en = (sb.size() != 0) && !tbl[k].b && !tbl[k].s;
            exp_d  = (sb.size() != 0) ? sb[0] : '0;
            tests_run += 3;
            if (out_en !== exp_en) begin
                tests_failed++;
                $display("[TB] FAIL average out_en step %0d: got %b want %b", k, out_en, exp_en);
            end
            if (dsoutdata !== exp_d) begin
                tests_failed++;
                $display("[TB] FAIL average data step %0d: got %0d want %0d", k, dsoutdata, exp_d);
            end
            if (ovf !== exp_ovf) begin
                tests_failed++;
                $display("[TB] FAIL average ovf step %0d: got %b want %b", k, ovf, exp_ovf);
            end
            if (exp_en) void'(sb.pop_front());
            if (tbl[k].s) begin sb.delete(); exp_ovf = 1'b0; end
            else if (tbl[k].v && tbl[k].done) begin
                if (sb.size() < 2) sb.push_back(14'(tbl[k].res)); else exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic test_backpressure();
        vec_t tbl[$];
        logic exp_en;
        logic signed [13:0] exp_d;
        do_reset();
        tbl.push_back(mk(1, 5, 1, 0, 0, 0, 1, 5));
        tbl.push_back(mk(1, 6, 1, 0, 0, 0, 1, 6));
        tbl.push_back(mk(1, 7, 1, 0, 0, 0, 1, 7));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        foreach (tbl[k]) begin
            step(tbl[k]);
            exp_en = (sb.size() != 0) && !tbl[k].b && !tbl[k].s;
            exp_d  = (sb.size() != 0) ? sb[0] : '0;
            tests_run += 3;
            if (out_en !== exp_en) begin
                tests_failed++;
                $display("[TB] FAIL backpressure out_en step %0d: got %b want %b", k, out_en, exp_en);
            end
            if (dsoutdata !== exp_d) begin
                tests_failed++;
                $display("[TB] FAIL backpressure data step %0d: got %0d want %0d", k, dsoutdata, exp_d);
            end
            if (ovf !== exp_ovf) begin
                tests_failed++;
                $display("[TB] FAIL backpressure ovf step %0d: got %b want %b", k, ovf, exp_ovf);
            end
            if (exp_en) void'(sb.pop_front());
            if (tbl[k].s) begin sb.delete(); exp_ovf = 1'b0; end
            else if (tbl[k].v && tbl[k].done) begin
                if (sb.size() < 2) sb.push_back(14'(tbl[k].res)); else exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic test_full_pushpop();
        vec_t tbl[$];
        logic exp_en;
        logic signed [13:0] exp_d;
        do_reset();
        tbl.push_back(mk(1, 10, 1, 0, 0, 0, 1, 10));
        tbl.push_back(mk(1, 11, 1, 0, 0, 0, 1, 11));
        tbl.push_back(mk(1, 12, 0, 0, 0, 0, 1, 12));
        for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        foreach (tbl[k]) begin
            step(tbl[k]);
            exp_en = (sb.size() != 0) && !tbl[k].b && !tbl[k].s;
            exp_d  = (sb.size() != 0) ? sb[0] : '0;
            tests_run += 3;
            if (out_en !== exp_en) begin
                tests_failed++;
                $display("[TB] FAIL pushpop out_en step %0d: got %b want %b", k, out_en, exp_en);
            end
            if (dsoutdata !== exp_d) begin
                tests_failed++;
                $display("[TB] FAIL pushpop data step %0d: got %0d want %0d", k, dsoutdata, exp_d);
            end
            if (ovf !== exp_ovf) begin
                tests_failed++;
                $display("[TB] FAIL pushpop ovf step %0d: got %b want %b", k, ovf, exp_ovf);
            end
            if (exp_en) void'(sb.pop_front());
            if (tbl[k].s) begin sb.delete(); exp_ovf = 1'b0; end
            else if (tbl[k].v && tbl[k].done) begin
                if (sb.size() < 2) sb.push_back(14'(tbl[k].res)); else exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic test_config_change();
        vec_t tbl[$];
        logic exp_en;
        logic signed [13:0] exp_d;
        do_reset();
        tbl.push_back(mk(1, 20, 0, 0, 2, 0, 0, 0));
        tbl.push_back(mk(1, 21, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 22, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 23, 0, 0, 1, 0, 1, 20));
        tbl.push_back(mk(1, 24, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 25, 0, 0, 1, 0, 1, 24));
        tbl.push_back(mk(1, 26, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 27, 0, 0, 1, 0, 1, 26));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
        foreach (tbl[k]) begin
            step(tbl[k]);
            exp_en = (sb.size() != 0) && !tbl[k].b && !tbl[k].s;
            exp_d  = (sb.size() != 0) ? sb[0] : '0;
            tests_run += 3;
            if (out_en !== exp_en) begin
                tests_failed++;
                $display("[TB] FAIL config out_en step %0d: got %b want %b", k, out_en, exp_en);
            end
            if (dsoutdata !== exp_d) begin
                tests_failed++;
                $display("[TB] FAIL config data step %0d: got %0d want %0d", k, dsoutdata, exp_d);
            end
            if (ovf !== exp_ovf) begin
                tests_failed++;
                $display("[TB] FAIL config ovf step %0d: got %b want %b", k, ovf, exp_ovf);
            end
            if (exp_en) void'(sb.pop_front());
            if (tbl[k].s) begin sb.delete(); exp_ovf = 1'b0; end
            else if (tbl[k].v && tbl[k].done) begin
                if (sb.size() < 2) sb.push_back(14'(tbl[k].res)); else exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic test_gaps();
        vec_t tbl[$];
        logic exp_en;
        logic signed [13:0] exp_d;
        do_reset();
        tbl.push_back(mk(1, 3, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 99, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 5, 0, 0, 1, 1, 1, 4));
        tbl.push_back(mk(0, 99, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 10, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, -77, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, -13, 0, 0, 1, 1, 1, -2));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
        foreach (tbl[k]) begin
            step(tbl[k]);
            exp_en = (sb.size() != 0) && !tbl[k].b && !tbl[k].s;
            exp_d  = (sb.size() != 0) ? sb[0] : '0;
            tests_run += 3;
            if (out_en !== exp_en) begin
                tests_failed++;
                $display("[TB] FAIL gaps out_en step %0d: got %b want %b", k, out_en, exp_en);
            end
            if (dsoutdata !== exp_d) begin
                tests_failed++;
                $display("[TB] FAIL gaps data step %0d: got %0d want %0d", k, dsoutdata, exp_d);
            end
            if (ovf !== exp_ovf) begin
                tests_failed++;
                $display("[TB] FAIL gaps ovf step %0d: got %b want %b", k, ovf, exp_ovf);
            end
            if (exp_en) void'(sb.pop_front());
            if (tbl[k].s) begin sb.delete(); exp_ovf = 1'b0; end
            else if (tbl[k].v && tbl[k].done) begin
                if (sb.size() < 2) sb.push_back(14'(tbl[k].res)); else exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic test_sync();
        vec_t tbl[$];
        logic exp_en;
        logic signed [13:0] exp_d;
        do_reset();
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 2, 1, 0, 0, 0, 1, 2));
        tbl.push_back(mk(1, 3, 1, 0, 0, 0, 1, 3));
        tbl.push_back(mk(1, 40, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 41, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 50, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 51, 0, 0, 1, 0, 1, 50));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
        foreach (tbl[k]) begin
            step(tbl[k]);
            exp_en = (sb.size() != 0) && !tbl[k].b && !tbl[k].s;
            exp_d  = (sb.size() != 0) ? sb[0] : '0;
            tests_run += 3;
            if (out_en !== exp_en) begin
                tests_failed++;
                $display("[TB] FAIL sync out_en step %0d: got %b want %b", k, out_en, exp_en);
            end
            if (dsoutdata !== exp_d) begin
                tests_failed++;
                $display("[TB] FAIL sync data step %0d: got %0d want %0d", k, dsoutdata, exp_d);
            end
            if (ovf !== exp_ovf) begin
                tests_failed++;
                $display("[TB] FAIL sync ovf step %0d: got %b want %b", k, ovf, exp_ovf);
            end
            if (exp_en) void'(sb.pop_front());
            if (tbl[k].s) begin sb.delete(); exp_ovf = 1'b0; end
            else if (tbl[k].v && tbl[k].done) begin
                if (sb.size() < 2) sb.push_back(14'(tbl[k].res)); else exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic test_async_reset();
        vec_t tbl[$];
        logic exp_en;
        logic signed [13:0] exp_d;
        do_reset();
        step(mk(1, 7, 1, 0, 0, 0, 0, 0));
        step(mk(1, 8, 1, 0, 0, 0, 0, 0));
        step(mk(1, 9, 1, 0, 0, 0, 0, 0));
        step(mk(1, 70, 1, 0, 1, 0, 0, 0));
        step(mk(0, 0, 0, 0, 1, 0, 0, 0));
        tests_run += 2;
        if (out_en !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL pre-reset out_en: got %b want 1", out_en);
        end
        if (ovf !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL pre-reset ovf: got %b want 1", ovf);
        end
        #2 rst = 1'b1;
        #1;
        tests_run += 3;
        if (out_en !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async reset out_en: got %b want 0", out_en);
        end
        if (dsoutdata !== 14'sd0) begin
            tests_failed++;
            $display("[TB] FAIL async reset data: got %0d want 0", dsoutdata);
        end
        if (ovf !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async reset ovf: got %b want 0", ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_ovf = 1'b0;
        tbl.push_back(mk(1, 60, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 61, 0, 0, 1, 0, 1, 60));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
        foreach (tbl[k]) begin
            step(tbl[k]);
            exp_en = (sb.size() != 0) && !tbl[k].b && !tbl[k].s;
            exp_d  = (sb.size() != 0) ? sb[0] : '0;
            tests_run += 3;
            if (out_en !== exp_en) begin
                tests_failed++;
                $display("[TB] FAIL post-reset out_en step %0d: got %b want %b", k, out_en, exp_en);
            end
            if (dsoutdata !== exp_d) begin
                tests_failed++;
                $display("[TB] FAIL post-reset data step %0d: got %0d want %0d", k, dsoutdata, exp_d);
            end
            if (ovf !== exp_ovf) begin
                tests_failed++;
                $display("[TB] FAIL post-reset ovf step %0d: got %b want %b", k, ovf, exp_ovf);
            end
            if (exp_en) void'(sb.pop_front());
            if (tbl[k].s) begin sb.delete(); exp_ovf = 1'b0; end
            else if (tbl[k].v && tbl[k].done) begin
                if (sb.size() < 2) sb.push_back(14'(tbl[k].res)); else exp_ovf = 1'b1;
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_ovf      = 1'b0;
        test_reset();
        test_pick();
        test_average();
        test_backpressure();
        test_full_pushpop();
        test_config_change();
        test_gaps();
        test_sync();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ds_decimator.md
Name: ds_decimator

Overview:
- Parametrised successor to the pass-through no-downsample stage, sitting between the ADC capture path and the downstream consumer (FFT/buffer) that drives outbusy.
- Reduces the input sample rate by a runtime power-of-two ratio, either by picking one sample per group or by boxcar averaging.
- Holds results in a 2-entry output FIFO so downstream backpressure does not lose data; flags an overflow when it must drop a result.

Parameters:
- DATA_WIDTH, 14, signed sample width in and out.
- MAX_LOG2, 4, largest decimation exponent (ratio up to 2^MAX_LOG2).
- LOG2_W, 3, width of ratio_log2 port; must hold MAX_LOG2.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- dataIn  in  DATA_WIDTH  signed input sample.
- in_valid  in  1  dataIn valid this cycle; no input backpressure.
- ratio_log2  in  LOG2_W  decimation exponent; ratio R = 2^ratio_log2.
- mode  in  1  0 = pick first sample of group, 1 = average of group.
- sync  in  1  synchronous restart: discards partial group, empties FIFO, clears ovf.
- dsoutdata  out  DATA_WIDTH  signed result at FIFO head.
- out_en  out  1  result valid and transferred this cycle.
- outbusy  in  1  downstream cannot accept.
- ovf  out  1  sticky: a completed result was dropped.

Behaviour:
- Reset (async, rst=1): group counter=0, accumulator=0, FIFO empty, dsoutdata=0, out_en=0, ovf=0; latched config = ratio 0, mode 0.
- Config latch: ratio_log2 and mode are latched on the first accepted sample of each group (count==0). Mid-group changes take effect at the next group.
- ratio_log2 > MAX_LOG2 is clamped to MAX_LOG2.
- Grouping: each in_valid=1 cycle increments the count. The group completes on the sample where count == R-1; the count then wraps to 0. in_valid=0 cycles are ignored and do not break the group.
- Pick mode: result = first sample of the group, held in a register.
- Average mode:
  - Accumulator is DATA_WIDTH+MAX_LOG2 bits, signed and sign-extended. It loads the first sample, then adds each subsequent sample.
  - result = (acc + last sample) >>> latched ratio_log2, arithmetic shift, truncating toward -inf, low DATA_WIDTH bits. No overflow is possible.
- R=1 (ratio_log2=0): every valid sample is a complete group; both modes pass the sample through.
- Push: the result is written into the FIFO on the clk edge of the group's last sample. It is visible at dsoutdata no earlier than the next cycle (1-cycle latency from the last sample).
- Output handshake:
  - out_en = FIFO non-empty AND !outbusy, combinational. A cycle with out_en=1 is a transfer and pops the head.
  - dsoutdata always shows the FIFO head; it is 0 when the FIFO is empty.
- FIFO depth is 2, in order.
  - Simultaneous push and pop is always legal, including when full: the push is accepted.
  - Push while full with no pop: the new result is dropped, ovf is set, and FIFO contents are unchanged.
- ovf stays 1 until sync or rst.
- sync=1:
  - Next state: count=0, accumulator=0, FIFO empty, ovf=0. The in_valid sample in the same cycle is discarded.
  - out_en is forced 0 in the sync cycle.
  - sync has priority over push/pop.
- rst mid-group or mid-transfer: immediate return to reset state; the partial group is lost.

Test Plan:
- Pick, ratio_log2=2, mode=0, in_valid=1, dataIn=0,1,2,…,11, outbusy=0 -> out_en pulses one cycle after samples 3, 7, 11; dsoutdata=0, 4, 8.
- Average, ratio_log2=2, mode=1, dataIn=-8191,-8192,-8192,-8192 then 1,2,2,2 -> results -8192 (−32767>>>2 = −8192) and 1 (7>>>2); width at most negative value is correct.
- Backpressure, ratio_log2=0, outbusy=1, dataIn=5,6,7 -> FIFO holds 5,6; 7 dropped, ovf=1. Then outbusy=0 -> out_en two cycles, dsoutdata 5 then 6; ovf stays 1.
- Full FIFO with simultaneous push/pop, ratio_log2=0: FIFO full (10,11), outbusy=0 on the same cycle as sample 12 -> 10 popped, 12 accepted, ovf=0; subsequent order 11, 12.
- Config change mid-group: ratio_log2 2→1 after sample 1 of a group -> the current group still completes after 4 samples; the next group completes after 2.
- Gaps and sync:
  - in_valid toggling 1,0,1,0,… with ratio_log2=1 -> one result per 2 valid samples.
  - sync asserted after 1 sample of a group, with FIFO non-empty and ovf=1 -> FIFO empty, ovf=0, next result is from the 2 samples after sync.
  - rst asserted asynchronously mid-clock -> all outputs 0 immediately.
